// File: rtl/stream_median_wake_pkg.sv
// Shared definitions for the binary 3x3 median / wake detector: FSM states and
// the majority rule applied to each window.
package stream_median_wake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } stateE;

    // A binary 3x3 median is 1 when at least this many of the nine pixels are 1.
    localparam int MAJORITY = 5;

    function automatic logic isMajority(input logic [8:0] win);
        int ones;
        ones = 0;
        for (int i = 0; i < 9; i++) begin
            ones += {31'd0, win[i]};
        end
        return (ones >= MAJORITY);
    endfunction

endpackage

// File: rtl/stream_median_wake_bin_line_buf.sv
// Two cascaded one-line delays for a 1-bit raster stream; both advance only
// when a pixel is accepted, so stalls leave the stored rows untouched.
module bin_line_buf #(
    parameter int IMG_W = 82
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic tap1,
    output logic tap2
);

    logic [IMG_W-1:0] line1;
    logic [IMG_W-1:0] line2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line1 <= '0;
            line2 <= '0;
        end else if (en) begin
            line1 <= {line1[IMG_W-2:0], din};
            line2 <= {line2[IMG_W-2:0], line1[IMG_W-1]};
        end
    end

    // tap1 is the pixel one row above the incoming one, tap2 two rows above.
    assign tap1 = line1[IMG_W-1];
    assign tap2 = line2[IMG_W-1];

endmodule

// File: rtl/stream_median_wake.sv
// Binary 3x3 median filter over a raster frame, counting active windows and
// raising a sticky wake request after FRAMES_N consecutive busy frames.
module stream_median_wake
    import stream_median_wake_pkg::*;
#(
    parameter int IMG_W    = 82,
    parameter int IMG_H    = 62,
    parameter int FRAMES_N = 2,
    parameter int CNT_W    = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pixValid,
    input  logic             pixIn,
    output logic             pixReady,
    input  logic [CNT_W-1:0] threshold,
    input  logic             wakeAck,
    output logic             medValid,
    output logic             medData,
    output logic [7:0]       medX,
    output logic [7:0]       medY,
    output logic             frameDone,
    output logic [CNT_W-1:0] activeCount,
    output logic             wakeUp
);

    localparam int              HIT_W   = (FRAMES_N > 1) ? $clog2(FRAMES_N + 1) : 1;
    localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(FRAMES_N);
    localparam logic [7:0]      X_LAST  = 8'(IMG_W - 1);
    localparam logic [7:0]      Y_LAST  = 8'(IMG_H - 1);

    stateE            state;
    logic [7:0]       xCnt;
    logic [7:0]       yCnt;
    logic [CNT_W-1:0] thrLatched;
    logic [HIT_W-1:0] hitCnt;
    logic [HIT_W-1:0] hitNext;
    logic             wakeSet;
    logic             accept;
    logic             tap1;
    logic             tap2;
    logic [2:0]       newCol;
    logic [2:0]       colPrev1;
    logic [2:0]       colPrev2;
    logic [8:0]       window;

    assign accept = pixReady && pixValid;
    // Columns are {row y-2, row y-1, row y}; colPrev1 is column x-1, colPrev2 is x-2.
    assign newCol = {tap2, tap1, pixIn};
    assign window = {colPrev2, colPrev1, newCol};

    bin_line_buf #(
        .IMG_W(IMG_W)
    ) lineBuf (
        .clk  (clk),
        .reset(reset),
        .en   (accept),
        .din  (pixIn),
        .tap1 (tap1),
        .tap2 (tap2)
    );

    always_comb begin
        hitNext = hitCnt;
        wakeSet = 1'b0;
        if (state == DONE) begin
            if (activeCount > thrLatched) begin
                hitNext = (hitCnt == HIT_MAX) ? HIT_MAX : hitCnt + 1'b1;
                wakeSet = (hitNext == HIT_MAX);
            end else begin
                hitNext = '0;
            end
        end
        if (wakeAck) begin
            hitNext = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pixReady    <= 1'b0;
            xCnt        <= '0;
            yCnt        <= '0;
            thrLatched  <= '0;
            hitCnt      <= '0;
            colPrev1    <= '0;
            colPrev2    <= '0;
            medValid    <= 1'b0;
            medData     <= 1'b0;
            medX        <= '0;
            medY        <= '0;
            frameDone   <= 1'b0;
            activeCount <= '0;
            wakeUp      <= 1'b0;
        end else begin
            medValid <= 1'b0;
            hitCnt   <= hitNext;
            // Wake set takes priority over a coincident acknowledge.
            wakeUp   <= wakeSet | (wakeUp & ~wakeAck);
            if (medValid && medData) begin
                activeCount <= activeCount + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        pixReady    <= 1'b1;
                        xCnt        <= '0;
                        yCnt        <= '0;
                        activeCount <= '0;
                        thrLatched  <= threshold;
                    end
                end
                RUN: begin
                    if (accept) begin
                        colPrev1 <= newCol;
                        colPrev2 <= colPrev1;
                        if (xCnt >= 8'd2 && yCnt >= 8'd2) begin
                            medValid <= 1'b1;
                            medData  <= isMajority(window);
                            medX     <= xCnt - 8'd1;
                            medY     <= yCnt - 8'd1;
                        end
                        if (xCnt == X_LAST) begin
                            xCnt <= '0;
                            if (yCnt == Y_LAST) begin
                                state    <= FLUSH;
                                pixReady <= 1'b0;
                            end else begin
                                yCnt <= yCnt + 8'd1;
                            end
                        end else begin
                            xCnt <= xCnt + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    // The final window is counted on this edge.
                    state     <= DONE;
                    frameDone <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    frameDone <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
